fft_buf_ctrl: RTL and testbench
===============================

Name: fft_buf_ctrl

Overview:
- Controller and arbiter for the 32-word x 16-bit FFT sample register bank.
- Shares the bank's single write port between CPU stores and accelerator writeback.
- Sequences one FFT pass: CPU load, accelerator start, compute wait with timeout, streamed writeback of 32 results, done.
- Sits between the core's memory-mapped write path, the FFT accelerator and the bank's en/we/accel_mem_en/addr/data inputs.

Parameters:
- DEPTH, 32, words in the bank; also the writeback beat count.
- WORDWIDTH, 16, sample width.
- ADDRW, 6, bank address width.
- TIMEOUT, 1024, maximum COMPUTE cycles before abort.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: asynchronous, active-high.
- cpu_en_i  in  1  CPU access request.
- cpu_we_i  in  1  CPU write enable.
- cpu_addr_i  in  ADDRW  CPU word address.
- cpu_data_i  in  32  CPU write data; low WORDWIDTH bits used.
- start_i  in  1  one-cycle pulse: launch an FFT pass.
- accel_start_o  out  1  one-cycle start pulse to accelerator.
- accel_done_i  in  1  accelerator finished computing.
- acc_valid_i  in  1  writeback beat valid.
- acc_data_i  in  WORDWIDTH  writeback beat data.
- acc_ready_o  out  1  controller accepts a writeback beat.
- mem_en_o  out  1  bank en_i.
- mem_we_o  out  1  bank we_i.
- mem_accel_en_o  out  1  bank accel_mem_en.
- mem_addr_o  out  ADDRW  bank addr_i.
- mem_data_o  out  32  bank data_i.
- cpu_stall_o  out  1  CPU write refused this cycle.
- busy_o  out  1  pass in progress.
- done_o  out  1  sticky: pass completed.
- err_o  out  1  sticky: compute timeout.
- addr_err_o  out  1  one-cycle pulse: CPU address >= DEPTH.

Behaviour:
- Reset: every output 0, state IDLE, counters 0. Bank contents are not touched.
- Reset asserted mid-pass aborts immediately; no further bank writes occur.
- All mem_* outputs are registered. A request or beat accepted in cycle N drives the bank in cycle N+1.
- States: IDLE, START, COMPUTE, WRITEBACK, DONE.
- IDLE/DONE, CPU write:
  - cpu_en_i && cpu_we_i with addr < DEPTH drives mem_en_o = mem_we_o = 1, addr and data forwarded next cycle.
  - addr >= DEPTH: write dropped, addr_err_o pulses next cycle.
  - cpu_en_i with !cpu_we_i: no bank write, no stall.
- start_i in IDLE/DONE:
  - Clears done_o and err_o.
  - Next state START.
  - A CPU write in the same cycle is still performed.
- START: accel_start_o = 1 for exactly one cycle, then COMPUTE.
- COMPUTE:
  - Timeout counter increments each cycle.
  - accel_done_i -> WRITEBACK with beat counter = 0.
  - Counter reaching TIMEOUT-1 without done -> IDLE with err_o = 1. accel_done_i in that same cycle wins.
- WRITEBACK:
  - acc_ready_o = 1 while beat counter < DEPTH.
  - Each acc_valid_i && acc_ready_o beat drives mem_accel_en_o = 1 next cycle, with mem_addr_o = beat counter and mem_data_o = zero-extended acc_data_i; the beat counter then increments.
  - Gaps in acc_valid_i are allowed, with no timeout.
  - Acceptance of beat DEPTH-1 -> DONE. acc_ready_o is 0 the cycle after.
- DONE: done_o = 1 until the next accepted start_i. CPU writes behave as in IDLE.
- Arbitration:
  - In START, COMPUTE and WRITEBACK, a CPU write raises cpu_stall_o combinationally that cycle and is dropped, not queued.
  - mem_we_o and mem_accel_en_o are never both 1.
- busy_o = 1 in START, COMPUTE and WRITEBACK.
- start_i outside IDLE/DONE is ignored.
- accel_done_i outside COMPUTE is ignored.
- acc_valid_i outside WRITEBACK is ignored.

Test Plan:
- Reset, then CPU writes addr 0..31 with data 0x1000+i -> mem_en_o = mem_we_o = 1 one cycle later, matching addr/data; no stalls; bank word 5 reads 0x1005.
- start_i; accel_done_i after 10 cycles; 32 back-to-back beats with data 0xA000+i -> one accel_start_o pulse, busy_o = 1, mem_accel_en_o on addr 0..31 in order, then done_o = 1, busy_o = 0, acc_ready_o = 0.
- CPU write to addr 3 during COMPUTE -> cpu_stall_o = 1 that cycle, no mem_en_o, bank word 3 unchanged.
- No accel_done_i for TIMEOUT cycles -> return to IDLE, err_o = 1; a new start_i clears err_o.
- CPU write to addr 40 -> addr_err_o pulse, no bank write. Simultaneous start_i and write to addr 7 in IDLE -> addr 7 written, START entered next cycle.
- rst asserted after 12 writeback beats -> all outputs 0 asynchronously, no further mem_accel_en_o; a fresh pass completes all 32 beats.

Source files
------------

// File: rtl/fft_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_buf_ctrl
// Description : Write-port arbiter and pass sequencer for the FFT sample bank
//               (CPU load, accelerator start/compute/writeback, done).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_buf_ctrl #(
    parameter int DEPTH     = 32,
    parameter int WORDWIDTH = 16,
    parameter int ADDRW     = 6,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_en_i,
    input  logic                 cpu_we_i,
    input  logic [ADDRW-1:0]     cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 start_i,
    output logic                 accel_start_o,
    input  logic                 accel_done_i,
    input  logic                 acc_valid_i,
    input  logic [WORDWIDTH-1:0] acc_data_i,
    output logic                 acc_ready_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic                 mem_accel_en_o,
    output logic [ADDRW-1:0]     mem_addr_o,
    output logic [31:0]          mem_data_o,
    output logic                 cpu_stall_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 addr_err_o
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_COMPUTE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TCW-1:0]   tcnt_q, tcnt_d;
    logic [ADDRW-1:0] beat_q, beat_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             aerr_q, aerr_d;
    logic             men_q, men_d;
    logic             mwe_q, mwe_d;
    logic             macc_q, macc_d;
    logic [ADDRW-1:0] maddr_q, maddr_d;
    logic [31:0]      mdata_q, mdata_d;

    logic w_idle_like;
    logic w_busy;
    logic w_cpu_wr;
    logic w_addr_ok;
    logic w_acc_ready;

    assign w_idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_busy      = (state_q == S_START) || (state_q == S_COMPUTE) ||
                         (state_q == S_WRITEBACK);
    assign w_cpu_wr    = cpu_en_i && cpu_we_i;
    assign w_addr_ok   = ({{(32-ADDRW){1'b0}}, cpu_addr_i} < DEPTH);
    assign w_acc_ready = (state_q == S_WRITEBACK) &&
                         ({{(32-ADDRW){1'b0}}, beat_q} < DEPTH);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        beat_d  = beat_q;
        done_d  = done_q;
        err_d   = err_q;
        aerr_d  = 1'b0;
        men_d   = 1'b0;
        mwe_d   = 1'b0;
        macc_d  = 1'b0;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // The full CPU word is forwarded; the bank keeps the low WORDWIDTH bits.
                if (w_cpu_wr) begin
                    if (w_addr_ok) begin
                        men_d   = 1'b1;
                        mwe_d   = 1'b1;
                        maddr_d = cpu_addr_i;
                        mdata_d = cpu_data_i;
                    end else begin
                        aerr_d = 1'b1;
                    end
                end
                if (start_i) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (accel_done_i) begin
                    beat_d  = '0;
                    state_d = S_WRITEBACK;
                end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                if (acc_valid_i && w_acc_ready) begin
                    macc_d  = 1'b1;
                    maddr_d = beat_q;
                    mdata_d = {{(32-WORDWIDTH){1'b0}}, acc_data_i};
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == ADDRW'(DEPTH - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            aerr_q  <= 1'b0;
            men_q   <= 1'b0;
            mwe_q   <= 1'b0;
            macc_q  <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            err_q   <= err_d;
            aerr_q  <= aerr_d;
            men_q   <= men_d;
            mwe_q   <= mwe_d;
            macc_q  <= macc_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
        end
    end

    // CPU writes during a pass are refused in the same cycle and never queued.
    assign cpu_stall_o    = w_cpu_wr && w_busy;
    assign accel_start_o  = (state_q == S_START);
    assign acc_ready_o    = w_acc_ready;
    assign busy_o         = w_busy;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign addr_err_o     = aerr_q;
    assign mem_en_o       = men_q;
    assign mem_we_o       = mwe_q;
    assign mem_accel_en_o = macc_q;
    assign mem_addr_o     = maddr_q;
    assign mem_data_o     = mdata_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_buf_ctrl
// Description : Directed bench for fft_buf_ctrl with a bank-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_buf_ctrl;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en_i, cpu_we_i;
    logic [5:0]  cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        start_i, accel_done_i, acc_valid_i;
    logic [15:0] acc_data_i;
    logic        accel_start_o, acc_ready_o, mem_en_o, mem_we_o, mem_accel_en_o;
    logic [5:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_stall_o, busy_o, done_o, err_o, addr_err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [15:0] bank[DEPTH];

    fft_buf_ctrl #(.DEPTH(DEPTH), .WORDWIDTH(16), .ADDRW(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_en_i(cpu_en_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .start_i(start_i), .accel_start_o(accel_start_o), .accel_done_i(accel_done_i),
        .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i), .acc_ready_o(acc_ready_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_accel_en_o(mem_accel_en_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .cpu_stall_o(cpu_stall_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .addr_err_o(addr_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input bit en, input bit we, input bit ac,
                                       input int a, input logic [31:0] d);
        return {23'b0, en, we, ac, a[5:0], d};
    endfunction

    function automatic logic [63:0] outs();
        return {16'b0, accel_start_o, acc_ready_o, mem_en_o, mem_we_o, mem_accel_en_o,
                mem_addr_o, mem_data_o, cpu_stall_o, busy_o, done_o, err_o, addr_err_o};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Every bank write the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        logic [63:0] obs;
        if (mem_en_o || mem_we_o || mem_accel_en_o) begin
            obs = {23'b0, mem_en_o, mem_we_o, mem_accel_en_o, mem_addr_o, mem_data_o};
            if (exp_q.size() == 0) chk("unexpected_write", obs, 64'd0);
            else                   chk("bank_write", obs, exp_q.pop_front());
            if (mem_we_o || mem_accel_en_o) bank[mem_addr_o[4:0]] = mem_data_o[15:0];
        end
    end

    task automatic beats(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            acc_valid_i = 1'b1;
            acc_data_i  = base + 16'(i);
            exp_q.push_back(pk(0, 0, 1, i, {16'h0, base + 16'(i)}));
            #1 chk("acc_ready_wb", acc_ready_o, 1);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_en_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        start_i = 0; accel_done_i = 0; acc_valid_i = 0; acc_data_i = '0;
        repeat (2) tick();
        #1 chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        tick();

        // CPU load of the whole bank
        for (int i = 0; i < DEPTH; i++) begin
            cpu_en_i = 1; cpu_we_i = 1; cpu_addr_i = 6'(i); cpu_data_i = 32'h1000 + i;
            exp_q.push_back(pk(1, 1, 0, i, 32'h1000 + i));
            #1 chk("stall_idle", cpu_stall_o, 0);
            tick();
        end
        cpu_en_i = 0; cpu_we_i = 0;
        tick();
        chk("bank5_load", bank[5], 16'h1005);
        chk("queue_empty_load", exp_q.size(), 0);

        cpu_en_i = 1; cpu_we_i = 0; cpu_addr_i = 6'd2;
        #1 chk("stall_read", cpu_stall_o, 0);
        tick();
        cpu_en_i = 0;

        // Normal pass with a refused CPU write during COMPUTE
        start_i = 1;
        #1 chk("busy_before_start", busy_o, 0);
        tick();
        start_i = 0;
        #1 chk("start_state", {accel_start_o, busy_o}, 2'b11);
        tick();
        #1 chk("compute_state", {accel_start_o, busy_o}, 2'b01);
        cpu_en_i = 1; cpu_we_i = 1; cpu_addr_i = 6'd3; cpu_data_i = 32'hDEAD;
        #1 chk("stall_compute", cpu_stall_o, 1);
        tick();
        cpu_en_i = 0; cpu_we_i = 0;
        repeat (7) tick();
        accel_done_i = 1;
        tick();
        accel_done_i = 0;
        beats(DEPTH, 16'hA000);
        acc_valid_i = 0;
        #1 chk("pass_done", {acc_ready_o, done_o, busy_o}, 3'b010);
        chk("bank3_kept_then_wb", bank[3], 16'hA003);
        chk("bank31_wb", bank[31], 16'hA01F);
        chk("queue_empty_pass", exp_q.size(), 0);
        acc_valid_i = 1;
        #1 chk("ready_in_done", acc_ready_o, 0);
        tick();
        acc_valid_i = 0;
        tick();

        // Timeout: COMPUTE lasts exactly TIMEOUT cycles without accel_done_i
        start_i = 1;
        tick();
        start_i = 0;
        #1 chk("done_cleared", done_o, 0);
        tick();
        repeat (TIMEOUT - 1) tick();
        #1 chk("compute_last_cycle", {busy_o, err_o}, 2'b10);
        tick();
        #1 chk("timeout_abort", {busy_o, err_o}, 2'b01);

        // Out-of-range address, then start with a simultaneous write
        cpu_en_i = 1; cpu_we_i = 1; cpu_addr_i = 6'd40; cpu_data_i = 32'h0BAD;
        #1 chk("stall_addr40", cpu_stall_o, 0);
        tick();
        cpu_en_i = 0; cpu_we_i = 0;
        #1 chk("addr_err_pulse", addr_err_o, 1);
        tick();
        #1 chk("addr_err_clear", addr_err_o, 0);
        start_i = 1; cpu_en_i = 1; cpu_we_i = 1; cpu_addr_i = 6'd7; cpu_data_i = 32'h7777;
        exp_q.push_back(pk(1, 1, 0, 7, 32'h7777));
        #1 chk("stall_start_write", cpu_stall_o, 0);
        tick();
        start_i = 0; cpu_en_i = 0; cpu_we_i = 0;
        #1 chk("start_clears_err", {accel_start_o, err_o}, 2'b10);
        chk("bank7_write", bank[7], 16'h7777);
        repeat (4) tick();
        accel_done_i = 1;
        tick();
        accel_done_i = 0;

        // Asynchronous reset after 12 beats
        beats(12, 16'hB000);
        acc_valid_i = 1; acc_data_i = 16'hB00C;
        #2 rst = 1;
        #1 chk("async_reset", outs(), 64'd0);
        repeat (2) tick();
        rst = 0; acc_valid_i = 0;
        tick();
        #1 chk("after_reset", outs(), 64'd0);
        chk("bank11_partial", bank[11], 16'hB00B);
        chk("bank12_untouched", bank[12], 16'hA00C);
        chk("queue_empty_reset", exp_q.size(), 0);

        // Fresh pass completes all beats
        start_i = 1;
        tick();
        start_i = 0;
        tick();
        accel_done_i = 1;
        tick();
        accel_done_i = 0;
        beats(DEPTH, 16'hC000);
        acc_valid_i = 0;
        #1 chk("fresh_done", {done_o, busy_o, acc_ready_o}, 3'b100);
        tick();
        chk("bank12_fresh", bank[12], 16'hC00C);
        chk("queue_empty_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
